pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_pc_reg.sv | 28 ++
 rtl/pc_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths, reset
// vector, NOP encoding and FSM state encoding.
// Optional build macro: FETCH_ALIGN_CHECK_EN (adds the HALT state).
package fetch_pkg;

    localparam int unsigned FETCH_XLEN         = 32;
    localparam logic [31:0] FETCH_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] FETCH_NOP          = 32'h0000_0013;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        ST_ISSUE   = 3'd0,
        ST_WAIT    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_DISCARD = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_e;
`else
    typedef enum logic [1:0] {
        ST_ISSUE   = 2'd0,
        ST_WAIT    = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } fetch_state_e;
`endif

    // A fetch target is misaligned when it is not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch program counter: reset > redirect > advance by 4 > hold.
// Arithmetic wraps modulo 2^XLEN.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            advance,
    output logic [XLEN-1:0] pc_q
);

    // Priority-muxed PC update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_VECTOR;
        end else if (redirect_en) begin
            pc_q <= redirect_pc;
        end else if (advance) begin
            pc_q <= pc_q + XLEN'(4);
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Single-outstanding-request instruction fetch unit.
// ISSUE sends one request, WAIT collects the response, HOLD presents the
// instruction to decode, DISCARD drops a response orphaned by a redirect.
// Optional build macro: FETCH_ALIGN_CHECK_EN -- a misaligned redirect target
// halts fetch and raises a sticky misalign_o; otherwise the target's low two
// bits are cleared.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = FETCH_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(FETCH_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic [XLEN-1:0] if_pcplus4_o,
    input  logic            id_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            misalign_o
);

    fetch_state_e    state_q;
    fetch_state_e    state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] redirect_tgt;
    logic            capture;

`ifdef FETCH_ALIGN_CHECK_EN
    logic            bad_target;
    logic            misalign_q;

    assign redirect_tgt = redirect_pc_i;
    assign bad_target   = redirect_i && is_misaligned(redirect_pc_i[1:0]);
    assign misalign_o   = misalign_q;

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else if (state_d == ST_HALT) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign redirect_tgt = redirect_pc_i & ~XLEN'(3);
    assign misalign_o   = 1'b0;
`endif

    // A response is accepted only in WAIT and only if no redirect overrides it.
    assign capture = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;

    fetch_pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect_en (redirect_i),
        .redirect_pc (redirect_tgt),
        .advance     (capture),
        .pc_q        (pc_q)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; redirect outranks rvalid and id_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ISSUE: begin
                state_d = redirect_i ? ST_DISCARD : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? ST_ISSUE : ST_DISCARD;
                end else if (imem_rvalid_i) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect_i || id_ready_i) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DISCARD: begin
                // A redirect alone keeps waiting for the orphan; if the orphan
                // arrives in the same cycle nothing is outstanding any more.
                if (imem_rvalid_i) begin
                    state_d = ST_ISSUE;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                state_d = ST_HALT;
            end
`endif
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
`ifdef FETCH_ALIGN_CHECK_EN
        if (bad_target) begin
            state_d = ST_HALT;
        end
`endif
    end

    // FSM outputs: request pulse in ISSUE, instruction valid in HOLD.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = pc_q;
        if_valid_o  = 1'b0;
        if (state_q == ST_ISSUE) begin
            imem_req_o = rst_n;
        end
        if (state_q == ST_HOLD) begin
            if_valid_o = !redirect_i;
        end
    end

    // Presented instruction and its PC, updated only on an accepted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_pc_o    <= '0;
            if_instr_o <= FETCH_NOP;
        end else if (capture) begin
            if_pc_o    <= pc_q;
            if_instr_o <= imem_rdata_i;
        end
    end

    assign if_pcplus4_o = if_pc_o + XLEN'(4);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pcplus4_o;
    logic        id_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        misalign_o;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_pcplus4_o  (if_pcplus4_o),
        .id_ready_i    (id_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From ISSUE: answer the request with one-cycle latency, ending in HOLD.
    task automatic respond(input logic [31:0] data);
        tick();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        tick();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
    endtask

    task automatic handshake();
        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = '0; id_ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = '0;
        repeat (3) tick();
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b exp 0", imem_req_o); end
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b exp 0", if_valid_o); end
        n_checks++; if (if_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL rst_instr: got %h exp 00000013", if_instr_o); end
        n_checks++; if (if_pc_o !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h exp 00000000", if_pc_o); end
        n_checks++; if (if_pcplus4_o !== 32'h4) begin n_fail++; $display("FAIL rst_pcplus4: got %h exp 00000004", if_pcplus4_o); end
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b exp 0", misalign_o); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rel_req: got %b exp 1", imem_req_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        for (int k = 0; k < 3; k++) begin
            exp_pc    = 32'(k * 4);
            exp_instr = 32'h0010_0093 + 32'(k);
            n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp_pc) begin n_fail++; $display("FAIL seq_req[%0d]: got req=%b addr=%h exp req=1 addr=%h", k, imem_req_o, imem_addr_o, exp_pc); end
            respond(exp_instr);
            n_checks++; if (if_valid_o !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b exp 1", k, if_valid_o); end
            n_checks++; if (if_pc_o !== exp_pc) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h exp %h", k, if_pc_o, exp_pc); end
            n_checks++; if (if_instr_o !== exp_instr) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h exp %h", k, if_instr_o, exp_instr); end
            n_checks++; if (if_pcplus4_o !== exp_pc + 32'h4) begin n_fail++; $display("FAIL seq_pcplus4[%0d]: got %h exp %h", k, if_pcplus4_o, exp_pc + 32'h4); end
            n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL seq_noreq[%0d]: got %b exp 0", k, imem_req_o); end
            handshake();
            n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL seq_drop[%0d]: got %b exp 0", k, if_valid_o); end
        end
    endtask

    task automatic test_hold_stall();
        n_checks++; if (imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL stall_addr: got %h exp 0000000c", imem_addr_o); end
        respond(32'h00a0_0093);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'hC || if_instr_o !== 32'h00a0_0093 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall[%0d]: got v=%b pc=%h ins=%h req=%b exp v=1 pc=0000000c ins=00a00093 req=0", c, if_valid_o, if_pc_o, if_instr_o, imem_req_o); end
        end
        // stray response while holding must not overwrite the instruction
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (if_instr_o !== 32'h00a0_0093 || if_valid_o !== 1'b1) begin n_fail++; $display("FAIL stray_rvalid: got ins=%h v=%b exp ins=00a00093 v=1", if_instr_o, if_valid_o); end
        handshake();
    endtask

    task automatic test_redirect_wait();
        n_checks++; if (imem_addr_o !== 32'h10) begin n_fail++; $display("FAIL rw_addr0: got %h exp 00000010", imem_addr_o); end
        tick();
        redirect_i = 1'b1; redirect_pc_i = 32'h100;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_noreq1: got %b exp 0", imem_req_o); end
        tick();
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_noreq2: got %b exp 0", imem_req_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0001;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL rw_req: got req=%b addr=%h exp req=1 addr=00000100", imem_req_o, imem_addr_o); end
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_stale_valid: got %b exp 0", if_valid_o); end
        respond(32'h0020_0113);
        n_checks++; if (if_pc_o !== 32'h100 || if_instr_o !== 32'h0020_0113) begin n_fail++; $display("FAIL rw_fetch: got pc=%h ins=%h exp pc=00000100 ins=00200113", if_pc_o, if_instr_o); end
        handshake();
    endtask

    task automatic test_redirect_same_cycle();
        n_checks++; if (imem_addr_o !== 32'h104) begin n_fail++; $display("FAIL sc_addr0: got %h exp 00000104", imem_addr_o); end
        tick();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0002;
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        imem_rvalid_i = 1'b0; redirect_i = 1'b0;
        n_checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h100) begin n_fail++; $display("FAIL sc_dropped: got v=%b pc=%h exp v=0 pc=00000100", if_valid_o, if_pc_o); end
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin n_fail++; $display("FAIL sc_req: got req=%b addr=%h exp req=1 addr=00000200", imem_req_o, imem_addr_o); end
        respond(32'h0030_0193);
        n_checks++; if (if_pc_o !== 32'h200 || if_instr_o !== 32'h0030_0193) begin n_fail++; $display("FAIL sc_fetch: got pc=%h ins=%h exp pc=00000200 ins=00300193", if_pc_o, if_instr_o); end
        handshake();
    endtask

    task automatic test_redirect_hold();
        n_checks++; if (imem_addr_o !== 32'h204) begin n_fail++; $display("FAIL rh_addr0: got %h exp 00000204", imem_addr_o); end
        respond(32'h0040_0213);
        id_ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h300;
        #1;
        n_checks++; if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL rh_no_handover: got %b exp 0", if_valid_o); end
        tick();
        id_ready_i = 1'b0; redirect_i = 1'b0;
        n_checks++; if (if_valid_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin n_fail++; $display("FAIL rh_req: got v=%b req=%b addr=%h exp v=0 req=1 addr=00000300", if_valid_o, imem_req_o, imem_addr_o); end
    endtask

    task automatic test_discard_redirect();
        redirect_i = 1'b1; redirect_pc_i = 32'h400;
        tick();
        redirect_pc_i = 32'h500;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL dr_noreq: got %b exp 0", imem_req_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0003;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h500) begin n_fail++; $display("FAIL dr_req: got req=%b addr=%h exp req=1 addr=00000500", imem_req_o, imem_addr_o); end
        respond(32'h0050_0293);
        n_checks++; if (if_pc_o !== 32'h500 || if_instr_o !== 32'h0050_0293) begin n_fail++; $display("FAIL dr_fetch: got pc=%h ins=%h exp pc=00000500 ins=00500293", if_pc_o, if_instr_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_i = 1'b0;
        n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h exp fffffffc", imem_addr_o); end
        respond(32'h0060_0313);
        n_checks++; if (if_pc_o !== 32'hFFFF_FFFC || if_pcplus4_o !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got pc=%h pc4=%h exp pc=fffffffc pc4=00000000", if_pc_o, if_pcplus4_o); end
        handshake();
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got req=%b addr=%h exp req=1 addr=00000000", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_misalign();
        respond(32'h0070_0393);
        redirect_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (misalign_o !== 1'b1 || imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin n_fail++; $display("FAIL halt[%0d]: got mis=%b req=%b v=%b exp mis=1 req=0 v=0", c, misalign_o, imem_req_o, if_valid_o); end
            imem_rvalid_i = (c == 1);
            tick();
            imem_rvalid_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("FAIL halt_rst: got %b exp 0", misalign_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL halt_restart: got req=%b addr=%h exp req=1 addr=00000000", imem_req_o, imem_addr_o); end
`else
        n_checks++; if (misalign_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin n_fail++; $display("FAIL align_force: got mis=%b req=%b addr=%h exp mis=0 req=1 addr=00000100", misalign_o, imem_req_o, imem_addr_o); end
`endif
    endtask

    task automatic test_reset_midreq();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req_o !== 1'b0 || if_valid_o !== 1'b0) begin n_fail++; $display("FAIL mr_rst: got req=%b v=%b exp req=0 v=0", imem_req_o, if_valid_o); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL mr_req: got req=%b addr=%h exp req=1 addr=00000000", imem_req_o, imem_addr_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0004;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (if_valid_o !== 1'b0 || if_instr_o !== 32'h0000_0013) begin n_fail++; $display("FAIL mr_late: got v=%b ins=%h exp v=0 ins=00000013", if_valid_o, if_instr_o); end
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0080_0413;
        tick();
        imem_rvalid_i = 1'b0;
        n_checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0080_0413) begin n_fail++; $display("FAIL mr_fetch: got v=%b pc=%h ins=%h exp v=1 pc=00000000 ins=00800413", if_valid_o, if_pc_o, if_instr_o); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_redirect_hold();
        test_discard_redirect();
        test_wrap();
        test_misalign();
        test_reset_midreq();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
